// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared constants, funct3 encodings, FSM state type and the
//               operand-signedness helper for the RV32M multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ITER   = 32;
    localparam int unsigned CNT_W  = $clog2(ITER);

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // Returns {op1_is_signed, op2_is_signed} for a given funct3.
    function automatic logic [1:0] operand_signed(input logic [2:0] f);
        logic [1:0] s;
        s = 2'b00;
        case (f)
            MD_MUL:    s = 2'b00;
            MD_MULH:   s = 2'b11;
            MD_MULHSU: s = 2'b10;
            MD_MULHU:  s = 2'b00;
            MD_DIV:    s = 2'b11;
            MD_DIVU:   s = 2'b00;
            MD_REM:    s = 2'b11;
            MD_REMU:   s = 2'b00;
            default:   s = 2'b00;
        endcase
        return s;
    endfunction

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_sign_fix.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sign_fix
// Description : Combinational conditional two's-complement negate. Used for
//               operand magnitude at start and result sign correction.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sign_fix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] in_val,
    input  logic             neg,
    output logic [WIDTH-1:0] out_val
);

    // Negate when requested, pass through otherwise.
    always_comb begin
        out_val = neg ? (~in_val + {{(WIDTH-1){1'b0}}, 1'b1}) : in_val;
    end

endmodule : muldiv_sign_fix
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit. Shift-add multiply and
//               restoring divide, one bit per cycle, 33-cycle latency.
//               Optional macro MULDIV_EARLY_OUT_EN: divide-by-zero, signed
//               overflow and zero-operand multiply finish in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          fn_q, fn_d;
    logic [XLEN-1:0]     m_q, m_d;        // multiplicand (mul) or divisor (div)
    logic [2*XLEN-1:0]   acc_q, acc_d;    // {hi, lo}: product, or {remainder, dividend/quotient}
    logic                neg_q, neg_d;    // final result must be negated
    logic                done_q, done_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic [1:0]          w_sgn_en;
    logic                w_s1, w_s2, w_op2_zero, w_neg_start;
    logic [XLEN-1:0]     w_op1_abs, w_op2_abs;
    logic [XLEN:0]       w_mul_sum;
    logic [XLEN:0]       w_div_sh;
    logic [XLEN-1:0]     w_div_sub;
    logic                w_div_ge;
    logic [2*XLEN-1:0]   w_step, w_fin_val, w_fin_fix;

    // Operand sign / magnitude decode for the incoming request.
    always_comb begin
        w_sgn_en   = operand_signed(funct3);
        w_s1       = op1[XLEN-1] & w_sgn_en[1];
        w_s2       = op2[XLEN-1] & w_sgn_en[0];
        w_op2_zero = (op2 == '0);
        if (funct3 == MD_DIV)
            w_neg_start = (w_s1 ^ w_s2) & ~w_op2_zero;   // x/0 quotient stays all-ones
        else if (funct3 == MD_REM)
            w_neg_start = w_s1;                          // remainder follows dividend
        else
            w_neg_start = w_s1 ^ w_s2;
    end

    muldiv_sign_fix #(.WIDTH(XLEN)) u_abs_op1 (
        .in_val (op1),
        .neg    (w_s1),
        .out_val(w_op1_abs)
    );

    muldiv_sign_fix #(.WIDTH(XLEN)) u_abs_op2 (
        .in_val (op2),
        .neg    (w_s2),
        .out_val(w_op2_abs)
    );

    // One iteration of either shift-add multiply or restoring divide.
    always_comb begin
        w_mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? m_q : {XLEN{1'b0}})};
        w_div_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        w_div_ge  = (w_div_sh >= {1'b0, m_q});
        w_div_sub = w_div_sh[XLEN-1:0] - m_q;
        if (fn_q[2])
            w_step = {(w_div_ge ? w_div_sub : w_div_sh[XLEN-1:0]),
                      acc_q[XLEN-2:0], w_div_ge};
        else
            w_step = {w_mul_sum, acc_q[XLEN-1:1]};
    end

    // Pick the value to sign-correct: full product, quotient or remainder.
    always_comb begin
        if (!fn_q[2])
            w_fin_val = acc_q;
        else if (fn_q[1])
            w_fin_val = {{XLEN{1'b0}}, acc_q[2*XLEN-1:XLEN]};
        else
            w_fin_val = {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
    end

    muldiv_sign_fix #(.WIDTH(2*XLEN)) u_fix_res (
        .in_val (w_fin_val),
        .neg    (neg_q),
        .out_val(w_fin_fix)
    );

`ifdef MULDIV_EARLY_OUT_EN
    logic              w_early;
    logic [2*XLEN-1:0] w_early_acc;

    // Detect requests whose answer is known without iterating.
    always_comb begin
        w_early     = 1'b0;
        w_early_acc = '0;
        if (funct3[2]) begin
            if (w_op2_zero) begin
                w_early     = 1'b1;
                w_early_acc = {w_op1_abs, {XLEN{1'b1}}};
            end else if (w_sgn_en[1] && (op1 == {1'b1, {(XLEN-1){1'b0}}})
                         && (op2 == {XLEN{1'b1}})) begin
                w_early     = 1'b1;
                w_early_acc = {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
            end
        end else if ((op1 == '0) || w_op2_zero) begin
            w_early     = 1'b1;
            w_early_acc = '0;
        end
    end
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fn_d     = fn_q;
        m_d      = m_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        result_d = result_q;
        done_d   = 1'b0;
        if (kill) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        fn_d    = funct3;
                        neg_d   = w_neg_start;
                        cnt_d   = CNT_W'(ITER - 1);
                        state_d = S_CALC;
                        if (funct3[2]) begin
                            m_d   = w_op2_abs;
                            acc_d = {{XLEN{1'b0}}, w_op1_abs};
                        end else begin
                            m_d   = w_op1_abs;
                            acc_d = {{XLEN{1'b0}}, w_op2_abs};
                        end
`ifdef MULDIV_EARLY_OUT_EN
                        if (w_early) begin
                            acc_d   = w_early_acc;
                            state_d = S_FIN;
                        end
`endif
                    end
                end
                S_CALC: begin
                    acc_d = w_step;
                    if (cnt_q == '0)
                        state_d = S_FIN;
                    else
                        cnt_d = cnt_q - 1'b1;
                end
                S_FIN: begin
                    result_d = ((fn_q == MD_MUL) || fn_q[2]) ? w_fin_fix[XLEN-1:0]
                                                             : w_fin_fix[2*XLEN-1:XLEN];
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            fn_q     <= '0;
            m_q      <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fn_q     <= fn_d;
            m_q      <= m_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule : muldiv_unit
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit: vector table plus
//               directed sequences for busy-start, back-to-back, kill, reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 33;
`endif
    localparam int NORMAL_LAT = 33;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        kill = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .funct3(funct3),
        .op1   (op1),
        .op2   (op2),
        .kill  (kill),
        .busy  (busy),
        .done  (done),
        .result(result)
    );

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          special;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Issue one operation and wait (bounded) for done; lat=-1 if none.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        @(negedge clk);
        start = 1'b1; funct3 = f; op1 = a; op2 = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        res = result;
    endtask

    vec_t        vecs[16];
    logic [31:0] res;
    int          lat;
    int          dcount;

    initial begin
        vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0}; // MUL 7*-3
        vecs[1]  = '{3'd1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0}; // MULH
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0}; // MULHU
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0}; // MULHSU -1*2
        vecs[4]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0}; // MULH min*min
        vecs[5]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0}; // DIV -7/2
        vecs[6]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0}; // REM -7/2
        vecs[7]  = '{3'd5, 32'd100,       32'd7,         32'd14,        1'b0}; // DIVU
        vecs[8]  = '{3'd7, 32'd100,       32'd7,         32'd2,         1'b0}; // REMU
        vecs[9]  = '{3'd4, 32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 1'b0}; // DIV 20/-3
        vecs[10] = '{3'd5, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1}; // DIVU x/0
        vecs[11] = '{3'd6, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b1}; // REM x/0
        vecs[12] = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1}; // DIV -7/0
        vecs[13] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1}; // DIV overflow
        vecs[14] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1}; // REM overflow
        vecs[15] = '{3'd0, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 1'b1}; // MUL 0*5

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 16; i++) begin
            do_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), lat,
                vecs[i].special ? SPECIAL_LAT : NORMAL_LAT);
        end

        // Start while busy is ignored; then back-to-back start in the done cycle
        @(negedge clk);
        start = 1'b1; funct3 = 3'd5; op1 = 32'd100; op2 = 32'd7;
        @(posedge clk); #1;                        // E0
        start = 1'b0;
        chk("busy_after_start", {31'b0, busy}, 32'd1);
        repeat (9) @(posedge clk);                 // E1..E9
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; op1 = 32'd3; op2 = 32'd3;
        @(posedge clk); #1;                        // E10
        start = 1'b0;
        lat = -1;
        for (int n = 11; n <= 45; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        chk("busy_start_latency", lat, 33);
        chk("busy_start_result", result, 32'd14);
        // Now in the done cycle, busy is low: issue the next op immediately.
        chk("done_cycle_busy", {31'b0, busy}, 32'd0);
        start = 1'b1; funct3 = 3'd4; op1 = 32'hFFFF_FFF9; op2 = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        chk("b2b_latency", lat, 33);
        chk("b2b_result", result, 32'hFFFF_FFFD);

        // Kill in the middle of a DIV
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; op1 = 32'd1000; op2 = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);                // through E15
        #1 kill = 1'b1;
        @(posedge clk); #1;                        // E16
        kill = 1'b0;
        chk("kill_busy", {31'b0, busy}, 32'd0);
        chk("kill_result_kept", result, 32'hFFFF_FFFD);
        dcount = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        chk("kill_no_done", dcount, 0);

        // kill together with start in IDLE: start dropped
        @(negedge clk);
        start = 1'b1; kill = 1'b1; funct3 = 3'd5; op1 = 32'd50; op2 = 32'd5;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        chk("kill_start_busy", {31'b0, busy}, 32'd0);

        // Operation after kill completes normally
        do_op(3'd5, 32'd100, 32'd7, res, lat);
        chk("post_kill_result", res, 32'd14);
        chk("post_kill_latency", lat, 33);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        start = 1'b1; funct3 = 3'd3; op1 = 32'hFFFF_FFFF; op2 = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {31'b0, busy}, 32'd0);
        chk("async_rst_done", {31'b0, done}, 32'd0);
        chk("async_rst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        chk("async_rst_no_done", dcount, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_muldiv_unit
`default_nettype wire
